ls132r_rr_arbiter: RTL
======================

# ls132r_rr_arbiter

Parametrised N-way arbiter built on first-one priority selection. It has a registered one-hot grant, a valid/ready handshake toward the shared resource, and an optional rotating (round-robin) pointer. Requesters can hold the grant across consecutive transfers with `lock`, and a burst-length limit prevents starvation. The block sits in front of shared ls132r resources such as the memory port, the EJTAG/debug bus and the refill path, and replaces ad-hoc fixed-priority selection.

## Interface
- `N`, 8: number of requesters, 2..64.
- `IDX_W`, 3: width of `gnt_idx`; must equal ceil(log2(N)).
- `RR`, 1: 1 selects round-robin priority; 0 selects fixed priority, where the lowest index wins.
- `MAX_LOCK`, 4: maximum consecutive transfers to one locked requester, 1..255.
- `clock`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req`  in  N  request per requester.
- `lock`  in  N  requester i wants to keep the grant after its current transfer.
- `gnt_ready`  in  1  resource accepts the granted requester this cycle.
- `gnt`  out  N  registered one-hot grant; all zeros when `gnt_valid`=0.
- `gnt_idx`  out  IDX_W  binary index of the granted requester; 0 when `gnt_valid`=0.
- `gnt_valid`  out  1  a grant is presented.

## Operation
- Priority pointer `ptr`, IDX_W bits. The candidate winner is the first set bit of `req` at or above `ptr`, wrapping modulo N. With `RR`=0, `ptr` is fixed at 0.
- Lock counter `lcnt`, 8 bits.
- Transfer: a cycle with `gnt_valid`=1 and `gnt_ready`=1.
- States:
  - IDLE: `gnt_valid`=0. If any `req` is set, load the winner at the next edge and go to GRANT. Otherwise stay.
  - GRANT: the grant is held unchanged until a transfer. `req`/`lock` changes and higher-priority requests are ignored. Requesters must hold `req` until accepted; the grant is never withdrawn.
  - On a transfer by requester i:
    - Go to LOCKED with grant unchanged if `lock[i]` and `req[i]` are both 1 and `lcnt`+1 < `MAX_LOCK`; `lcnt` increments.
    - Otherwise re-arbitrate. Set `ptr` to (i+1) mod N when `RR`=1, and clear `lcnt`. Load the winner from the current `req` using the updated `ptr`, giving a back-to-back grant with no bubble. Requester i's own `req` bit is still eligible, at lowest priority. If no `req` is set, go to IDLE.
  - LOCKED: same handshake as GRANT. The release rule above applies on each transfer.
- Forced release: when `lcnt`+1 reaches `MAX_LOCK`, release even if `lock[i]`=1. With `MAX_LOCK`=1, `lock` has no effect.
- Wrap-around: after a transfer by requester N-1, `ptr` is 0. `N` not a power of 2: index arithmetic is modulo N, never 2^IDX_W.
- `gnt` and `gnt_idx` always agree. `gnt` is one-hot or zero.
- Reset (asserted at any time, including mid-grant): `gnt`=0, `gnt_idx`=0, `gnt_valid`=0, `ptr`=0, `lcnt`=0, state IDLE. After reset deassertion, the first edge may grant.

## Timing
- Request to grant latency from IDLE: 1 cycle (`req` sampled at edge k, `gnt_valid`=1 after edge k).
- Transfer to next grant: 0 bubble cycles. The new grant is valid in the cycle after the transfer if any `req` is set.
- Sustained throughput: one transfer per cycle with `gnt_ready` held at 1.
- All outputs are driven directly from flops. There is no combinational path from `req`, `lock` or `gnt_ready` to the outputs.
- Combinational depth: rotate, first-one search, then rotate-back; must close at ls132r core frequency for N=64.

## Test plan
- Reset and idle: assert `reset` mid-GRANT with N=8 -> outputs 0 on that cycle. After release with `req`=0, outputs stay 0. Then `req`=8'h10 -> `gnt`=8'h10, `gnt_idx`=4 one cycle later.
- Round-robin fairness: N=8, `RR`=1, `req`=8'hFF, `gnt_ready`=1 constant -> `gnt_idx` sequence 0,1,...,7,0 with one grant per cycle. With `RR`=0 the same stimulus gives 0 every cycle.
- Handshake stall: `req`=8'h06, `gnt_ready`=0 for 5 cycles, `req[1]` dropped at cycle 3 -> `gnt` stays 8'h02, `gnt_idx`=1 for all 5 cycles. After `gnt_ready`=1 the next grant is `gnt_idx`=2.
- Lock limit: `MAX_LOCK`=4, `req`=8'h03, `lock`=8'h01, `gnt_ready`=1 -> 4 consecutive grants to 0, then forced release to 1, then 0 again.
- Non-power-of-2 wrap: N=5, IDX_W=3, `req`=5'h11 -> grants alternate 0,4,0,4. `gnt_idx` never reaches 5..7.
- Random soak: random `req`/`lock`/`gnt_ready` for 10k cycles. Check: no grant changes without a transfer; `gnt` one-hot or zero; every requester holding `req` is granted within N×`MAX_LOCK` transfers.

Source files
------------

// File: rtl/ls132r_rr_arbiter.sv
// ls132r_rr_arbiter
// N-way arbiter with a registered one-hot grant, a valid/ready handshake
// toward the shared resource, optional round-robin priority and grant locking
// bounded by MAX_LOCK consecutive transfers.
//
// Ports
//   clock      : single clock, rising edge
//   reset      : asynchronous, active-high
//   req[N]     : request per requester (held until accepted)
//   lock[N]    : requester wants to keep the grant after its transfer
//   gnt_ready  : resource accepts the presented grant this cycle
//   gnt[N]     : registered one-hot grant, zero when gnt_valid=0
//   gnt_idx    : binary index of gnt, zero when gnt_valid=0
//   gnt_valid  : a grant is presented
//
// state  | meaning
// IDLE   | no grant presented, waiting for any request
// GRANT  | grant presented, held until the resource accepts it
// LOCKED | same holder re-granted after a locked transfer
module ls132r_rr_arbiter #(
    parameter int N        = 8,
    parameter int IDX_W    = 3,
    parameter int RR       = 1,
    parameter int MAX_LOCK = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     lock,
    input  logic             gnt_ready,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;

    logic [IDX_W-1:0]  ptr;
    logic [IDX_W-1:0]  ptr_d;
    logic [7:0]        lcnt;
    logic [7:0]        lcnt_d;
    logic [N-1:0]      gnt_d;
    logic [IDX_W-1:0]  gnt_idx_d;
    logic              gnt_valid_d;

    logic              any_req;
    logic              xfer;
    logic              keep;
    logic              rel;
    logic [IDX_W-1:0]  ptr_after;
    logic [IDX_W-1:0]  arb_ptr;
    logic [N-1:0]      rot;
    logic [IDX_W:0]    off;
    logic [IDX_W:0]    sum;
    logic [IDX_W-1:0]  win_idx;

    assign any_req = |req;
    assign xfer    = gnt_valid & gnt_ready;

    // The holder keeps the grant only while it still requests, asks to lock,
    // and has not used up its MAX_LOCK transfers.
    assign keep = (|(gnt & lock & req)) &
                  (({1'b0, lcnt} + 9'd1) < 9'(MAX_LOCK));
    assign rel  = xfer & ~keep;

    // Pointer moves just past the releasing holder, wrapping at N (not 2^IDX_W).
    always_comb begin
        ptr_after = '0;
        if (RR != 0) begin
            if (gnt_idx == IDX_W'(N - 1))
                ptr_after = '0;
            else
                ptr_after = gnt_idx + IDX_W'(1);
        end
    end

    // On a release the new pointer is used in the same cycle so the next
    // grant follows without a bubble.
    assign arb_ptr = rel ? ptr_after : ptr;

    // Rotate so arb_ptr sits at bit 0, find the first one, rotate back mod N.
    always_comb begin
        rot = N'({req, req} >> arb_ptr);
        off = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (rot[j])
                off = (IDX_W + 1)'(j);
        end
        sum = {1'b0, arb_ptr} + off;
        if (sum >= (IDX_W + 1)'(N))
            sum = sum - (IDX_W + 1)'(N);
        win_idx = sum[IDX_W-1:0];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            ptr       <= '0;
            lcnt      <= '0;
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr       <= ptr_d;
            lcnt      <= lcnt_d;
            gnt       <= gnt_d;
            gnt_idx   <= gnt_idx_d;
            gnt_valid <= gnt_valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (any_req)
                    state_d = GRANT;
            end
            GRANT, LOCKED: begin
                if (xfer) begin
                    if (keep)
                        state_d = LOCKED;
                    else if (any_req)
                        state_d = GRANT;
                    else
                        state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Next values of the output and pointer/counter flops.
    always_comb begin
        gnt_d       = gnt;
        gnt_idx_d   = gnt_idx;
        gnt_valid_d = gnt_valid;
        ptr_d       = ptr;
        lcnt_d      = lcnt;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    gnt_d       = N'(1) << win_idx;
                    gnt_idx_d   = win_idx;
                    gnt_valid_d = 1'b1;
                end
            end
            GRANT, LOCKED: begin
                if (xfer && keep) begin
                    lcnt_d = lcnt + 8'd1;
                end else if (rel) begin
                    ptr_d  = ptr_after;
                    lcnt_d = '0;
                    if (any_req) begin
                        gnt_d       = N'(1) << win_idx;
                        gnt_idx_d   = win_idx;
                        gnt_valid_d = 1'b1;
                    end else begin
                        gnt_d       = '0;
                        gnt_idx_d   = '0;
                        gnt_valid_d = 1'b0;
                    end
                end
            end
            default: begin
                gnt_d       = '0;
                gnt_idx_d   = '0;
                gnt_valid_d = 1'b0;
                ptr_d       = '0;
                lcnt_d      = '0;
            end
        endcase
    end

endmodule
